// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared helpers for the async FIFO pointer logic (read and write controllers).
// bin2gray / gray2bin work on a 32-bit container. Zero-extended narrower
// pointers convert correctly; callers cast the result back to pointer width.
package fifo_rd_ctrl_pkg;

    localparam int unsigned FN_W = 32;

    // Binary to reflected Gray code.
    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
        logic [FN_W-1:0] b;
        b = g;
        for (int i = 1; i < int'(FN_W); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// First-word-fall-through output stream of the FIFO read side.
//   m_data  : output data word
//   m_valid : m_data holds a word
//   m_ready : consumer accepts m_data this cycle
interface fifo_rd_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_rd_ctrl_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing clock domains.
//   clk, rst_n : destination clock, async active-low reset (clears to 0)
//   i_d        : source-domain registered value
//   o_q        : synchronized value (second stage)
module fifo_rd_ctrl_sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q1;
    logic [W-1:0] r_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= i_d;
            r_q2 <= r_q1;
        end
    end

    assign o_q = r_q2;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO.
// Owns the read pointer (binary + Gray), synchronizes the write Gray pointer,
// produces empty / almost_empty / rd_level and feeds a FWFT output register.
//   r_clk, r_rst_n  : read clock, async active-low reset
//   wptr_gray_async : write Gray pointer (unsynchronized)
//   rptr_gray       : registered read Gray pointer to the write domain
//   raddr, rd_rq    : fifo_mem read address / read request (rd_rq = pop)
//   empty           : registered empty flag, also to fifo_mem
//   rdata_mem       : fifo_mem read data
//   m_if            : output stream (m_data / m_valid / m_ready)
//   rd_level        : words in memory, excluding the output register
//   almost_empty    : rd_level <= AE_THRESH
module fifo_rd_ctrl
    import fifo_rd_ctrl_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned AE_THRESH = 2,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                r_clk,
    input  logic                r_rst_n,
    input  logic [ADDR_W:0]     wptr_gray_async,
    output logic [ADDR_W:0]     rptr_gray,
    output logic [ADDR_W-1:0]   raddr,
    output logic                rd_rq,
    output logic                empty,
    input  logic [WIDTH-1:0]    rdata_mem,
    fifo_rd_ctrl_if.master      m_if,
    output logic [ADDR_W:0]     rd_level,
    output logic                almost_empty
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Registered state
    ptr_t             r_rptr_bin;
    ptr_t             r_rptr_gray;
    ptr_t             r_level;
    logic             r_empty;
    logic             r_ae;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;

    // Combinational next-state
    ptr_t             w_wq2;
    ptr_t             w_wbin_s;
    ptr_t             w_rptr_nxt;
    ptr_t             w_rptr_gray_nxt;
    ptr_t             w_level_nxt;
    logic             w_pop;
    logic             w_empty_nxt;
    logic             w_ae_nxt;
    logic             w_m_valid_nxt;
    logic [WIDTH-1:0] w_m_data_nxt;

    // Bring the write Gray pointer into the read domain.
    fifo_rd_ctrl_sync_2ff #(
        .W (PTR_W)
    ) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (r_rst_n),
        .i_d   (wptr_gray_async),
        .o_q   (w_wq2)
    );

    // Pop decision, pointer advance, flags and output-register next state.
    always_comb begin
        w_wbin_s        = PTR_W'(gray2bin(FN_W'(w_wq2)));
        w_pop           = 1'b0;
        w_rptr_nxt      = r_rptr_bin;
        w_rptr_gray_nxt = r_rptr_gray;
        w_level_nxt     = r_level;
        w_empty_nxt     = r_empty;
        w_ae_nxt        = r_ae;
        w_m_valid_nxt   = r_m_valid;
        w_m_data_nxt    = r_m_data;

        // Fetch a new word whenever the output register is free or being drained.
        w_pop = !r_empty && (!r_m_valid || m_if.m_ready);

        w_rptr_nxt      = r_rptr_bin + PTR_W'(w_pop);
        w_rptr_gray_nxt = PTR_W'(bin2gray(FN_W'(w_rptr_nxt)));

        // The wrap bit makes the Gray compare exact across laps.
        w_empty_nxt = (w_rptr_gray_nxt == w_wq2);
        w_level_nxt = w_wbin_s - w_rptr_nxt;
        w_ae_nxt    = (w_level_nxt <= PTR_W'(AE_THRESH));

        if (w_pop) begin
            w_m_valid_nxt = 1'b1;
            w_m_data_nxt  = rdata_mem;
        end else if (r_m_valid && m_if.m_ready) begin
            w_m_valid_nxt = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_rptr_bin  <= '0;
            r_rptr_gray <= '0;
            r_level     <= '0;
            r_empty     <= 1'b1;
            r_ae        <= 1'b1;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
        end else begin
            r_rptr_bin  <= w_rptr_nxt;
            r_rptr_gray <= w_rptr_gray_nxt;
            r_level     <= w_level_nxt;
            r_empty     <= w_empty_nxt;
            r_ae        <= w_ae_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_m_data    <= w_m_data_nxt;
        end
    end

    assign rptr_gray    = r_rptr_gray;
    assign raddr        = r_rptr_bin[ADDR_W-1:0];
    assign rd_rq        = w_pop;
    assign empty        = r_empty;
    assign rd_level     = r_level;
    assign almost_empty = r_ae;
    assign m_if.m_data  = r_m_data;
    assign m_if.m_valid = r_m_valid;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: models fifo_mem and the write side, keeps a
// count-based model of the read side and compares it every cycle.
module tb_fifo_rd_ctrl;

    localparam int unsigned AE = 2;

    logic       r_clk;
    logic       r_rst_n;
    logic [4:0] w_gray;
    logic [4:0] rptr_gray;
    logic [3:0] raddr;
    logic       rd_rq;
    logic       empty;
    logic [7:0] rdata_mem;
    logic [4:0] rd_level;
    logic       almost_empty;

    logic [7:0] tb_mem  [0:15];
    logic [7:0] wr_data [0:255];
    int         w_cnt;

    int n_chk;
    int n_pass;

    // Read-side model: counts of words written / read, and sync history.
    int         md_rd;
    int         md_s1;
    int         md_s2;
    int         md_level;
    logic       md_valid;
    logic [7:0] md_data;
    logic       e_pop;
    logic [7:0] dq [$];

    fifo_rd_ctrl_if #(.WIDTH(8)) m_if ();

    assign rdata_mem = tb_mem[raddr];

    fifo_rd_ctrl #(
        .WIDTH     (8),
        .DEPTH     (16),
        .AE_THRESH (2)
    ) dut (
        .r_clk           (r_clk),
        .r_rst_n         (r_rst_n),
        .wptr_gray_async (w_gray),
        .rptr_gray       (rptr_gray),
        .raddr           (raddr),
        .rd_rq           (rd_rq),
        .empty           (empty),
        .rdata_mem       (rdata_mem),
        .m_if            (m_if),
        .rd_level        (rd_level),
        .almost_empty    (almost_empty)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    function automatic logic [4:0] g5(input int b);
        logic [4:0] x;
        x = 5'(b % 32);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #2;
    endtask

    task automatic write_word(input logic [7:0] d);
        tb_mem[w_cnt % 16] = d;
        wr_data[w_cnt]     = d;
        w_cnt++;
        w_gray = g5(w_cnt);
    endtask

    task automatic wait_deliv(input int n, input int budget);
        for (int i = 0; i < budget && dq.size() < n; i++) tick();
        chk("deliv_count", 32'(dq.size()), 32'(n));
    endtask

    task automatic do_reset();
        @(posedge r_clk);
        #4;
        r_rst_n = 1'b0;
        w_cnt   = 0;
        w_gray  = '0;
        dq.delete();
        repeat (2) @(posedge r_clk);
        #2;
        r_rst_n = 1'b1;
    endtask

    // Per-cycle compare against the model, then advance the model one edge.
    initial begin
        forever begin
            @(negedge r_clk);
            if (!r_rst_n) begin
                md_rd = 0; md_s1 = 0; md_s2 = 0; md_level = 0;
                md_valid = 1'b0; md_data = '0;
            end
            e_pop = r_rst_n && (md_level != 0) && (!md_valid || m_if.m_ready);
            chk("empty",        32'(empty),        32'(md_level == 0));
            chk("almost_empty", 32'(almost_empty), 32'(md_level <= int'(AE)));
            chk("rd_level",     32'(rd_level),     32'(md_level));
            chk("rptr_gray",    32'(rptr_gray),    32'(g5(md_rd)));
            chk("raddr",        32'(raddr),        32'(md_rd % 16));
            chk("m_valid",      32'(m_if.m_valid), 32'(md_valid));
            chk("m_data",       32'(m_if.m_data),  32'(md_data));
            chk("rd_rq",        32'(rd_rq),        32'(e_pop));
            if (r_rst_n) begin
                if (md_valid && m_if.m_ready) dq.push_back(m_if.m_data);
                if (e_pop) begin
                    md_data  = wr_data[md_rd];
                    md_valid = 1'b1;
                    md_rd++;
                end else if (m_if.m_ready) begin
                    md_valid = 1'b0;
                end
                md_level = md_s2 - md_rd;
                md_s2    = md_s1;
                md_s1    = w_cnt;
            end
        end
    end

    initial begin
        n_chk = 0; n_pass = 0;
        for (int i = 0; i < 16; i++) tb_mem[i] = '0;
        r_rst_n       = 1'b1;
        w_cnt         = 0;
        w_gray        = '0;
        m_if.m_ready  = 1'b1;

        // 1: reset asserted mid-clock takes effect immediately
        #7;
        r_rst_n = 1'b0;
        #1;
        chk("rst_empty",     32'(empty),        32'd1);
        chk("rst_m_valid",   32'(m_if.m_valid), 32'd0);
        chk("rst_rptr_gray", 32'(rptr_gray),    32'd0);
        chk("rst_rd_level",  32'(rd_level),     32'd0);
        repeat (2) @(posedge r_clk);
        #2;
        r_rst_n = 1'b1;

        // 2: single word latency
        tick();
        write_word(8'hA5);
        repeat (4) @(negedge r_clk);
        chk("t2_empty_e3",   32'(empty),        32'd0);
        chk("t2_valid_e3",   32'(m_if.m_valid), 32'd0);
        @(negedge r_clk);
        chk("t2_valid_e4",   32'(m_if.m_valid), 32'd1);
        chk("t2_data_e4",    32'(m_if.m_data),  32'hA5);
        chk("t2_empty_e4",   32'(empty),        32'd1);
        tick();

        // 3: fill 16 words while stalled, then drain
        do_reset();
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            write_word(8'(i));
        end
        repeat (6) tick();
        chk("t3_level_full", 32'(rd_level),     32'd15);
        chk("t3_ae_full",    32'(almost_empty), 32'd0);
        chk("t3_head",       32'(m_if.m_data),  32'h00);
        m_if.m_ready = 1'b1;
        wait_deliv(16, 60);
        for (int i = 0; i < 16; i++) chk("t3_order", 32'(dq[i]), 32'(i));
        repeat (2) tick();
        chk("t3_empty_end",  32'(empty),        32'd1);
        chk("t3_ae_end",     32'(almost_empty), 32'd1);
        chk("t3_valid_end",  32'(m_if.m_valid), 32'd0);

        // 4: three laps of 16 words across both pointer wraps
        do_reset();
        for (int i = 0; i < 48; i++) begin
            tick();
            write_word(8'(i) ^ 8'h5A);
        end
        wait_deliv(48, 40);
        for (int i = 0; i < 48; i++) chk("t4_order", 32'(dq[i]), 32'(8'(i) ^ 8'h5A));
        repeat (2) tick();
        chk("t4_rptr_gray",  32'(rptr_gray), 32'b11000);
        chk("t4_empty",      32'(empty),     32'd1);

        // 5: backpressure with 4 words queued
        do_reset();
        m_if.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            write_word(8'hC0 + 8'(i));
        end
        repeat (10) tick();
        chk("t5_hold_data",  32'(m_if.m_data),  32'hC0);
        chk("t5_hold_valid", 32'(m_if.m_valid), 32'd1);
        chk("t5_rd_rq",      32'(rd_rq),        32'd0);
        chk("t5_rptr_gray",  32'(rptr_gray),    32'd1);
        chk("t5_rd_level",   32'(rd_level),     32'd3);
        m_if.m_ready = 1'b1;
        wait_deliv(4, 20);
        for (int i = 0; i < 4; i++) chk("t5_order", 32'(dq[i]), 32'(8'hC0 + 8'(i)));

        // 6: reset in the middle of a stream, then a fresh word
        do_reset();
        for (int i = 0; i < 40 && dq.size() < 5; i++) begin
            tick();
            if (w_cnt < 10) write_word(8'h60 + 8'(i));
        end
        chk("t6_pre_count",  32'(dq.size() >= 5), 32'd1);
        #2;
        r_rst_n = 1'b0;
        #1;
        chk("t6_rst_valid",  32'(m_if.m_valid), 32'd0);
        chk("t6_rst_rptr",   32'(rptr_gray),    32'd0);
        chk("t6_rst_empty",  32'(empty),        32'd1);
        chk("t6_rst_level",  32'(rd_level),     32'd0);
        w_cnt  = 0;
        w_gray = '0;
        dq.delete();
        repeat (2) @(posedge r_clk);
        #2;
        r_rst_n = 1'b1;
        tick();
        write_word(8'h3C);
        wait_deliv(1, 20);
        chk("t6_post_word",  32'(dq[0]), 32'h3C);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
